// File: rtl/alu_md_unit_if.sv
// Execute-stage ALU request/response bundle: operation offer with operands, registered result, HI/LO view.
// Latency: none (wires only).
// Backpressure: in_ready from the slave gates the in_valid offer; outputs have no ready.
interface alu_md_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       aluop;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport slave (
    input  in_valid, aluop, funct, a, b,
    output in_ready, out_valid, result, hi, lo
  );

  modport master (
    output in_valid, aluop, funct, a, b,
    input  in_ready, out_valid, result, hi, lo
  );
endinterface

// File: rtl/alu_md_unit.sv
// MIPS execute ALU with aluop/funct decode plus iterative unsigned multu/divu writing HI/LO.
// Latency: 1 cycle for single-cycle ops; WIDTH cycles for multu/divu.
// Backpressure: in_ready drops for the WIDTH busy cycles of multu/divu; single-cycle ops run 1/cycle.
module alu_md_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  alu_md_if.slave  bus
);
  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] CNT_INIT = SW'(WIDTH - 1);

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_SLLV  = 6'b000100;
  localparam logic [5:0] F_SRLV  = 6'b000110;
  localparam logic [5:0] F_SRAV  = 6'b000111;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [SW-1:0]      cnt;
  logic               in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   result;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  // Shared iteration register: multu keeps {partial sum, remaining multiplier},
  // divu keeps {partial remainder, remaining dividend / growing quotient}.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               div_zero;

  logic               accept;
  logic               is_mul;
  logic               is_div;
  logic               last;
  logic [SW-1:0]      shamt;
  logic [WIDTH-1:0]   alu_res;

  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [WIDTH:0]     shifted;
  logic               ge;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   rem_nxt;
  logic [2*WIDTH-1:0] div_nxt;
  logic [WIDTH-1:0]   div_hi;
  logic [WIDTH-1:0]   div_lo;

  assign accept = bus.in_valid && (state == IDLE);
  assign is_mul = (bus.aluop == 3'b111) && (bus.funct == F_MULTU);
  assign is_div = (bus.aluop == 3'b111) && (bus.funct == F_DIVU);
  assign last   = (cnt == '0);
  assign shamt  = bus.a[SW-1:0];

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = result;
  assign bus.hi        = hi;
  assign bus.lo        = lo;

  // One shift-add step: add multiplicand into the upper half when the next multiplier bit is set, then shift right.
  always_comb begin
    msum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_nxt = {msum, acc[WIDTH-1:1]};
  end

  // One restoring-division step: shift in the next dividend bit, subtract divisor if it fits.
  always_comb begin
    shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge      = (shifted >= {1'b0, opnd});
    diff    = shifted[WIDTH-1:0] - opnd;
    rem_nxt = ge ? diff : shifted[WIDTH-1:0];
    div_nxt = {rem_nxt, acc[WIDTH-2:0], ge};
    // With a zero divisor the register never iterates, so its low half still holds the dividend.
    div_hi  = div_zero ? acc[WIDTH-1:0] : div_nxt[2*WIDTH-1:WIDTH];
    div_lo  = div_zero ? '1 : div_nxt[WIDTH-1:0];
  end

  // Single-cycle result decode from aluop, falling through to funct for R-type.
  always_comb begin
    alu_res = '0;
    case (bus.aluop)
      3'b000: alu_res = bus.a + bus.b;
      3'b001: alu_res = bus.a & bus.b;
      3'b010: alu_res = bus.b << (WIDTH / 2);
      3'b011: alu_res = bus.a | bus.b;
      3'b100: alu_res = bus.a ^ bus.b;
      3'b101: alu_res = bus.a - bus.b;
      3'b110: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      default: begin
        case (bus.funct)
          F_ADD:   alu_res = bus.a + bus.b;
          F_SUB:   alu_res = bus.a - bus.b;
          F_AND:   alu_res = bus.a & bus.b;
          F_OR:    alu_res = bus.a | bus.b;
          F_XOR:   alu_res = bus.a ^ bus.b;
          F_NOR:   alu_res = ~(bus.a | bus.b);
          F_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
          F_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
          F_SLLV:  alu_res = bus.b << shamt;
          F_SRLV:  alu_res = bus.b >> shamt;
          F_SRAV:  alu_res = $signed(bus.b) >>> shamt;
          F_MFHI:  alu_res = hi;
          F_MFLO:  alu_res = lo;
          default: alu_res = '0;
        endcase
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake: only IDLE accepts; busy states leave on the final iteration.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept && is_mul)      state_nxt = MUL;
        else if (accept && is_div) state_nxt = DIV;
      end
      MUL:     if (last) state_nxt = IDLE;
      DIV:     if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands at accept, iterate while busy, commit HI/LO/result on the last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      hi        <= '0;
      lo        <= '0;
      acc       <= '0;
      opnd      <= '0;
      div_zero  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mul || is_div) begin
              acc      <= {{WIDTH{1'b0}}, bus.a};
              opnd     <= bus.b;
              div_zero <= is_div && (bus.b == '0);
              cnt      <= CNT_INIT;
            end else begin
              result    <= alu_res;
              out_valid <= 1'b1;
            end
          end
        end
        MUL: begin
          acc <= mul_nxt;
          if (last) begin
            hi        <= mul_nxt[2*WIDTH-1:WIDTH];
            lo        <= mul_nxt[WIDTH-1:0];
            result    <= mul_nxt[WIDTH-1:0];
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DIV: begin
          if (!div_zero) acc <= div_nxt;
          if (last) begin
            hi        <= div_hi;
            lo        <= div_lo;
            result    <= div_lo;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_md_unit.sv
// Self-checking bench for alu_md_unit: directed cases with literal expectations plus random traffic.
// Latency: the reference model predicts single-cycle results one edge after accept, multu/divu W edges after.
// Backpressure: the model only accepts an offer when no multu/divu is outstanding.
module tb_alu_md_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  alu_md_if #(.WIDTH(W)) bus ();

  alu_md_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic for single-cycle ops, straight from the opcode tables.
  function automatic logic [W-1:0] ref_op(input logic [2:0] al, input logic [5:0] fn,
                                          input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [W-1:0] h, input logic [W-1:0] l);
    int sa;
    sa = int'(x % W);
    case (al)
      3'd0: return x + y;
      3'd1: return x & y;
      3'd2: return y * 65536;
      3'd3: return x | y;
      3'd4: return x ^ y;
      3'd5: return x - y;
      3'd6: return ($signed(x) < $signed(y)) ? 1 : 0;
      default: case (fn)
        6'b100000: return x + y;
        6'b100010: return x - y;
        6'b100100: return x & y;
        6'b100101: return x | y;
        6'b100110: return x ^ y;
        6'b100111: return ~(x | y);
        6'b101010: return ($signed(x) < $signed(y)) ? 1 : 0;
        6'b101011: return (x < y) ? 1 : 0;
        6'b000100: return y << sa;
        6'b000110: return y >> sa;
        6'b000111: return W'($signed(y) >>> sa);
        6'b010000: return h;
        6'b010010: return l;
        default:   return '0;
      endcase
    endcase
  endfunction

  // Behavioural model state.
  int         busy_left;
  logic [W-1:0] m_hi, m_lo, m_res, p_hi, p_lo;
  logic       m_ov;

  // Model: one step per clock edge; busy countdown in whole cycles, products via native arithmetic.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_left = 0; m_hi = '0; m_lo = '0; m_res = '0; m_ov = 1'b0; p_hi = '0; p_lo = '0;
    end else begin
      m_ov = 1'b0;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_res = p_lo; m_ov = 1'b1;
        end
      end else if (bus.in_valid) begin
        if (bus.aluop == 3'b111 && bus.funct == 6'b011001) begin
          {p_hi, p_lo} = 64'(bus.a) * 64'(bus.b);
          busy_left = W;
        end else if (bus.aluop == 3'b111 && bus.funct == 6'b011011) begin
          if (bus.b == 0) begin p_hi = bus.a; p_lo = '1; end
          else begin p_hi = bus.a % bus.b; p_lo = bus.a / bus.b; end
          busy_left = W;
        end else begin
          m_res = ref_op(bus.aluop, bus.funct, bus.a, bus.b, m_hi, m_lo);
          m_ov  = 1'b1;
        end
      end
    end
  end

  logic chk_en = 1'b0;

  // Compare process: every cycle outside reset, all outputs against the model.
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      chk("in_ready",  W'(bus.in_ready),  W'(busy_left == 0));
      chk("out_valid", W'(bus.out_valid), W'(m_ov));
      chk("result",    bus.result, m_res);
      chk("hi",        bus.hi, m_hi);
      chk("lo",        bus.lo, m_lo);
    end
  end

  task automatic step(input logic v, input logic [2:0] al, input logic [5:0] fn,
                      input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    bus.in_valid = v; bus.aluop = al; bus.funct = fn; bus.a = x; bus.b = y;
    @(posedge clk);
    #1;
  endtask

  // Keep offering adds while busy; return edges from accept until out_valid (0 if it never came).
  task automatic wait_done(output int n);
    n = 0;
    for (int k = 1; k <= W + 8; k++) begin
      step(1'b1, 3'b000, 6'd0, $urandom, $urandom);
      if (bus.out_valid) begin n = k; break; end
    end
    if (n == 0) begin
      nerr++;
      $display("FAIL timeout: no out_valid within %0d cycles", W + 8);
    end
  endtask

  logic [5:0] ftab [16];
  int lat;

  initial begin
    ftab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
             6'b101010, 6'b101011, 6'b000100, 6'b000110, 6'b000111, 6'b010000,
             6'b010010, 6'b011001, 6'b011011, 6'b111111};
    bus.in_valid = 1'b0; bus.aluop = '0; bus.funct = '0; bus.a = '0; bus.b = '0;
    #1 rst = 1'b1;
    #20;
    chk("rst_in_ready",  W'(bus.in_ready), 1);
    chk("rst_out_valid", W'(bus.out_valid), 0);
    chk("rst_result",    bus.result, 0);
    chk("rst_hi",        bus.hi, 0);
    chk("rst_lo",        bus.lo, 0);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // Logic ops back to back.
    step(1, 3'b111, 6'b100100, 32'h0000F0F0, 32'h00FF00FF); chk("and", bus.result, 32'h000000F0);
    step(1, 3'b111, 6'b100101, 32'h0000F0F0, 32'h00FF00FF); chk("or",  bus.result, 32'h00FFF0FF);
    chk("or_valid", W'(bus.out_valid), 1);
    step(1, 3'b111, 6'b100111, 32'h0000F0F0, 32'h00FF00FF); chk("nor", bus.result, 32'hFF000F00);
    chk("nor_valid", W'(bus.out_valid), 1);
    step(1, 3'b111, 6'b100110, 32'h0000F0F0, 32'h00FF00FF); chk("xor", bus.result, 32'h00FFF00F);
    chk("xor_valid", W'(bus.out_valid), 1);
    step(1, 3'b010, 6'd0, 32'h0, 32'h00001234);              chk("lui",  bus.result, 32'h12340000);
    step(1, 3'b111, 6'b101010, 32'hFFFFFFFF, 32'h1);         chk("slt",  bus.result, 32'h1);
    step(1, 3'b111, 6'b101011, 32'hFFFFFFFF, 32'h1);         chk("sltu", bus.result, 32'h0);
    step(1, 3'b111, 6'b000111, 32'h4, 32'h80000000);         chk("srav", bus.result, 32'hF8000000);

    // multu all-ones, then mfhi in the completion cycle.
    step(1, 3'b111, 6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("mul_busy", W'(bus.in_ready), 0);
    wait_done(lat);
    chk("mul_lat", W'(lat), W);
    chk("mul_hi", bus.hi, 32'hFFFFFFFE);
    chk("mul_lo", bus.lo, 32'h00000001);
    chk("mul_res", bus.result, 32'h00000001);
    step(1, 3'b111, 6'b010000, 32'h0, 32'h0);                chk("mfhi", bus.result, 32'hFFFFFFFE);

    // divu normal and divide-by-zero.
    step(1, 3'b111, 6'b011011, 32'd100, 32'd7);
    wait_done(lat);
    chk("div_lo", bus.lo, 32'd14);
    chk("div_hi", bus.hi, 32'd2);
    step(1, 3'b111, 6'b011011, 32'd5, 32'd0);
    wait_done(lat);
    chk("div0_lat", W'(lat), W);
    chk("div0_hi", bus.hi, 32'd5);
    chk("div0_lo", bus.lo, 32'hFFFFFFFF);

    // Reset during multu.
    step(1, 3'b111, 6'b011001, $urandom, $urandom);
    repeat (9) step(0, 3'b000, 6'd0, 32'd0, 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_ready", W'(bus.in_ready), 1);
    chk("abort_hi", bus.hi, 0);
    chk("abort_lo", bus.lo, 0);
    chk("abort_ov", W'(bus.out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    step(1, 3'b000, 6'd0, 32'd3, 32'd4);                     chk("add", bus.result, 32'd7);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      logic       v;
      logic [2:0] al;
      logic [5:0] fn;
      logic [W-1:0] x, y;
      v  = ($urandom_range(0, 3) != 0);
      al = (($urandom_range(0, 19)) < 7) ? 3'($urandom_range(0, 6)) : 3'b111;
      fn = ftab[$urandom_range(0, 15)];
      if (fn == 6'b111111) fn = 6'($urandom);
      x  = $urandom;
      y  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      step(v, al, fn, x, y);
    end
    repeat (W + 4) step(0, 3'b000, 6'd0, 32'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
